// File: rtl/arm_mc_controller_if.sv
// arm_mc_controller_if: instruction/flag inputs and control outputs shared
// between the multicycle ARM controller (master) and its datapath (slave).
interface arm_mc_controller_if #(
    parameter int ALUCTRL_W = 2,
    parameter int FLAGS_W   = 4
);
    logic [19:0]          Instr;
    logic [FLAGS_W-1:0]   ALUFlags;
    logic                 PCWrite;
    logic                 MemWrite;
    logic                 RegWrite;
    logic                 IRWrite;
    logic                 AdrSrc;
    logic [1:0]           RegSrc;
    logic [1:0]           ImmSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ResultSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 MoveOp;
    logic [3:0]           State;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl, MoveOp, State
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUControl, MoveOp, State
    );
endinterface

// File: rtl/arm_mc_controller.sv
// arm_mc_controller: multicycle ARM control unit. One FSM sequences fetch,
// decode, execute and writeback; control outputs are registered for the
// state being entered. Define ARM_CMP_EN to decode CMP (funct 1010, S=1),
// which writes flags and returns straight to FETCH without a writeback.
module arm_mc_controller #(
    parameter int ALUCTRL_W = 2,
    parameter int FLAGS_W   = 4
) (
    input  logic                clk,
    input  logic                reset,
    arm_mc_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'd0);
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'd1);
    localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'd2);
    localparam logic [ALUCTRL_W-1:0] ALU_ORR = ALUCTRL_W'(3'd3);
    localparam logic [ALUCTRL_W-1:0] ALU_EOR = ALUCTRL_W'(3'd4);

    // Standard ARM condition evaluation against NZCV; 1111 never executes.
    function automatic logic cond_ex_f(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'h0:    cond_ex_f = z;
            4'h1:    cond_ex_f = ~z;
            4'h2:    cond_ex_f = c;
            4'h3:    cond_ex_f = ~c;
            4'h4:    cond_ex_f = n;
            4'h5:    cond_ex_f = ~n;
            4'h6:    cond_ex_f = v;
            4'h7:    cond_ex_f = ~v;
            4'h8:    cond_ex_f = c & ~z;
            4'h9:    cond_ex_f = ~c | z;
            4'hA:    cond_ex_f = (n == v);
            4'hB:    cond_ex_f = (n != v);
            4'hC:    cond_ex_f = ~z & (n == v);
            4'hD:    cond_ex_f = z | (n != v);
            4'hE:    cond_ex_f = 1'b1;
            default: cond_ex_f = 1'b0;
        endcase
    endfunction

    state_t                 state_r;
    state_t                 nxt_state_s;
    state_t                 tgt_state_s;
    logic [3:0]             flags_r;

    logic                   pcwrite_r, memwrite_r, regwrite_r, irwrite_r, adrsrc_r, moveop_r;
    logic [1:0]             alusrca_r, alusrcb_r, resultsrc_r;
    logic [ALUCTRL_W-1:0]   aluctrl_r;

    logic                   nxt_pcwrite_s, nxt_memwrite_s, nxt_regwrite_s, nxt_irwrite_s;
    logic                   nxt_adrsrc_s, nxt_moveop_s;
    logic [1:0]             nxt_alusrca_s, nxt_alusrcb_s, nxt_resultsrc_s;
    logic [ALUCTRL_W-1:0]   nxt_aluctrl_s;

    logic [ALUCTRL_W-1:0]   alu_code_s;
    logic                   alu_def_s, alu_arith_s, alu_mov_s, alu_cmp_s;

    logic [3:0]             cond_s;
    logic [1:0]             op_s;
    logic [5:0]             funct_s;
    logic [3:0]             rd_s;
    logic                   condex_s;
    logic                   rd_pc_s;
    logic                   in_exec_s;
    logic                   unused_s;

    assign cond_s    = bus.Instr[19:16];
    assign op_s      = bus.Instr[15:14];
    assign funct_s   = bus.Instr[13:8];
    assign rd_s      = bus.Instr[3:0];
    assign rd_pc_s   = (rd_s == 4'hF);
    // Condition uses the flags held before this instruction's own update.
    assign condex_s  = cond_ex_f(cond_s, flags_r);
    assign in_exec_s = (state_r == S_EXECUTER) || (state_r == S_EXECUTEI);
    assign unused_s  = ^bus.Instr[7:4];

    // Data-processing command decode: ALU code, defined/arith/move/compare.
    always_comb begin
        alu_code_s  = ALU_ADD;
        alu_def_s   = 1'b1;
        alu_arith_s = 1'b0;
        alu_mov_s   = 1'b0;
        alu_cmp_s   = 1'b0;
        case (funct_s[4:1])
            4'b0100: begin alu_code_s = ALU_ADD; alu_arith_s = 1'b1; end
            4'b0010: begin alu_code_s = ALU_SUB; alu_arith_s = 1'b1; end
            4'b0000: alu_code_s = ALU_AND;
            4'b1100: alu_code_s = ALU_ORR;
            4'b1101: alu_mov_s  = 1'b1;
            4'b0001: begin
                if (ALUCTRL_W >= 3) alu_code_s = ALU_EOR;
                else                alu_def_s  = 1'b0;
            end
`ifdef ARM_CMP_EN
            4'b1010: begin
                if (funct_s[0]) begin
                    alu_code_s  = ALU_SUB;
                    alu_arith_s = 1'b1;
                    alu_cmp_s   = 1'b1;
                end else begin
                    alu_def_s   = 1'b0;
                end
            end
`endif
            default: alu_def_s = 1'b0;
        endcase
    end

    // Next-state selection; reset always targets FETCH.
    always_comb begin
        nxt_state_s = S_FETCH;
        case (state_r)
            S_FETCH:  nxt_state_s = S_DECODE;
            S_DECODE: begin
                case (op_s)
                    2'b01:   nxt_state_s = S_MEMADR;
                    2'b10:   nxt_state_s = S_BRANCH;
                    2'b00:   nxt_state_s = funct_s[5] ? S_EXECUTEI : S_EXECUTER;
                    default: nxt_state_s = S_FETCH;
                endcase
            end
            S_MEMADR:   nxt_state_s = funct_s[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    nxt_state_s = S_MEMWB;
            S_EXECUTER,
            S_EXECUTEI: nxt_state_s = alu_cmp_s ? S_FETCH : S_ALUWB;
            default:    nxt_state_s = S_FETCH;
        endcase
        if (reset) tgt_state_s = S_FETCH;
        else       tgt_state_s = nxt_state_s;
    end

    // Control values for the state about to be entered.
    always_comb begin
        nxt_pcwrite_s   = 1'b0;
        nxt_memwrite_s  = 1'b0;
        nxt_regwrite_s  = 1'b0;
        nxt_irwrite_s   = 1'b0;
        nxt_adrsrc_s    = 1'b0;
        nxt_moveop_s    = 1'b0;
        nxt_alusrca_s   = 2'b00;
        nxt_alusrcb_s   = 2'b00;
        nxt_resultsrc_s = 2'b00;
        nxt_aluctrl_s   = ALU_ADD;
        case (tgt_state_s)
            S_FETCH: begin
                nxt_irwrite_s   = 1'b1;
                nxt_pcwrite_s   = 1'b1;
                nxt_alusrca_s   = 2'b01;
                nxt_alusrcb_s   = 2'b10;
                nxt_resultsrc_s = 2'b10;
            end
            S_DECODE: begin
                nxt_alusrca_s   = 2'b01;
                nxt_alusrcb_s   = 2'b10;
                nxt_resultsrc_s = 2'b10;
            end
            S_MEMADR: begin
                nxt_alusrcb_s   = 2'b01;
            end
            S_MEMRD: begin
                nxt_adrsrc_s    = 1'b1;
            end
            S_MEMWB: begin
                nxt_resultsrc_s = 2'b01;
                nxt_regwrite_s  = condex_s;
                nxt_pcwrite_s   = condex_s & rd_pc_s;
            end
            S_MEMWR: begin
                nxt_adrsrc_s    = 1'b1;
                nxt_memwrite_s  = condex_s;
            end
            S_EXECUTER: begin
                nxt_aluctrl_s   = alu_code_s;
                nxt_moveop_s    = alu_mov_s;
            end
            S_EXECUTEI: begin
                nxt_alusrcb_s   = 2'b01;
                nxt_aluctrl_s   = alu_code_s;
                nxt_moveop_s    = alu_mov_s;
            end
            S_ALUWB: begin
                nxt_regwrite_s  = condex_s & alu_def_s;
                nxt_pcwrite_s   = condex_s & rd_pc_s;
            end
            S_BRANCH: begin
                nxt_alusrca_s   = 2'b10;
                nxt_alusrcb_s   = 2'b01;
                nxt_resultsrc_s = 2'b10;
                nxt_pcwrite_s   = condex_s;
            end
            default: begin
                nxt_aluctrl_s   = ALU_ADD;
            end
        endcase
    end

    // FSM state, registered controls and NZCV flag register.
    always_ff @(posedge clk) begin
        state_r     <= tgt_state_s;
        pcwrite_r   <= nxt_pcwrite_s;
        memwrite_r  <= nxt_memwrite_s;
        regwrite_r  <= nxt_regwrite_s;
        irwrite_r   <= nxt_irwrite_s;
        adrsrc_r    <= nxt_adrsrc_s;
        moveop_r    <= nxt_moveop_s;
        alusrca_r   <= nxt_alusrca_s;
        alusrcb_r   <= nxt_alusrcb_s;
        resultsrc_r <= nxt_resultsrc_s;
        aluctrl_r   <= nxt_aluctrl_s;
        if (reset) begin
            flags_r <= 4'b0000;
        end else if (in_exec_s && funct_s[0] && condex_s && alu_def_s) begin
            flags_r[3:2] <= bus.ALUFlags[3:2];
            if (alu_arith_s) flags_r[1:0] <= bus.ALUFlags[1:0];
        end
    end

    // Write enables are masked by reset so no write commits in a reset cycle.
    assign bus.PCWrite    = pcwrite_r  & ~reset;
    assign bus.MemWrite   = memwrite_r & ~reset;
    assign bus.RegWrite   = regwrite_r & ~reset;
    assign bus.IRWrite    = irwrite_r  & ~reset;
    assign bus.AdrSrc     = adrsrc_r;
    assign bus.ALUSrcA    = alusrca_r;
    assign bus.ALUSrcB    = alusrcb_r;
    assign bus.ResultSrc  = resultsrc_r;
    assign bus.ALUControl = aluctrl_r;
    assign bus.MoveOp     = moveop_r;
    assign bus.State      = state_r;
    // Register-address and extend selects follow the instruction directly.
    assign bus.RegSrc     = {(op_s == 2'b01), (op_s == 2'b10)};
    assign bus.ImmSrc     = op_s;
endmodule

// File: tb/tb_arm_mc_controller.sv
// tb_arm_mc_controller: random and directed instructions checked cycle by
// cycle against a path/flag model of the multicycle controller.
module tb_arm_mc_controller;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [3:0] mflags;

    arm_mc_controller_if #(.ALUCTRL_W(AW), .FLAGS_W(4)) bus ();
    arm_mc_controller #(.ALUCTRL_W(AW), .FLAGS_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ARM rule: cond[3:1] picks a test, cond[0] inverts it; 1110 always, 1111 never.
    function automatic bit cond_holds(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v, b;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0:    b = z;
            3'd1:    b = c;
            3'd2:    b = n;
            3'd3:    b = v;
            3'd4:    b = c && !z;
            3'd5:    b = (n == v);
            3'd6:    b = !z && (n == v);
            default: return (cond == 4'hE);
        endcase
        return b ^ cond[0];
    endfunction

    function automatic void alu_info(input logic [5:0] funct, output int code, output bit def,
                                     output bit arith, output bit mov, output bit cmp);
        code = 0; def = 1; arith = 0; mov = 0; cmp = 0;
        case (funct[4:1])
            4'b0100: arith = 1;
            4'b0010: begin code = 1; arith = 1; end
            4'b0000: code = 2;
            4'b1100: code = 3;
            4'b1101: mov = 1;
            4'b0001: if (AW >= 3) code = 4; else def = 0;
            4'b1010: begin
`ifdef ARM_CMP_EN
                if (funct[0]) begin code = 1; arith = 1; cmp = 1; end
                else def = 0;
`else
                def = 0;
`endif
            end
            default: def = 0;
        endcase
    endfunction

    // Expected control word and which fields are defined for a state.
    function automatic void exp_ctl(input int st, input logic [3:0] rd, input bit cx, input bit def,
                                    input int code, input bit mov,
                                    output logic [14:0] v, output logic [14:0] m);
        logic pcw, mw, rw, irw, adr, mo;
        logic [1:0] sa, sb, rs;
        logic [2:0] ac;
        bit madr, msa, msb, mrs, mac;
        {pcw, mw, rw, irw, adr, mo} = 6'b0;
        sa = 2'b00; sb = 2'b00; rs = 2'b00; ac = 3'b000;
        {madr, msa, msb, mrs, mac} = 5'b0;
        case (st)
            0: begin pcw = 1; irw = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10;
                     madr = 1; msa = 1; msb = 1; mrs = 1; mac = 1; end
            1: begin sa = 2'b01; sb = 2'b10; rs = 2'b10; msa = 1; msb = 1; mrs = 1; end
            2: begin sb = 2'b01; msa = 1; msb = 1; mac = 1; end
            3: begin adr = 1; madr = 1; mrs = 1; end
            4: begin rs = 2'b01; rw = cx; pcw = cx && (rd == 4'hF); mrs = 1; end
            5: begin adr = 1; mw = cx; madr = 1; mrs = 1; end
            6, 7: begin sb = (st == 7) ? 2'b01 : 2'b00; ac = 3'(code); mo = def && mov;
                        msa = 1; msb = 1; mac = def; end
            8: begin rw = cx && def; pcw = cx && (rd == 4'hF); mrs = 1; end
            9: begin sa = 2'b10; sb = 2'b01; rs = 2'b10; pcw = cx; msa = 1; msb = 1; mrs = 1; mac = 1; end
            default: ;
        endcase
        v = {pcw, mw, rw, irw, adr, sa, sb, rs, ac, mo};
        m = {5'b11111, {2{msa}}, {2{msb}}, {2{mrs}}, {3{mac}}, 1'b1};
    endfunction

    function automatic logic [14:0] obs_ctl();
        return {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc,
                bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, 3'(bus.ALUControl), bus.MoveOp};
    endfunction

    function automatic logic [19:0] rand_instr();
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        logic [7:0] lo;
        cond  = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
        op    = 2'($urandom_range(0, 3));
        funct = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 5))
                0:       funct[4:1] = 4'b0100;
                1:       funct[4:1] = 4'b0010;
                2:       funct[4:1] = 4'b0000;
                3:       funct[4:1] = 4'b1100;
                4:       funct[4:1] = 4'b1101;
                default: funct[4:1] = 4'b1010;
            endcase
        end
        lo = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) lo[3:0] = 4'hF;
        return {cond, op, funct, lo};
    endfunction

    // Run one instruction; the next falling edge must be its FETCH cycle.
    task automatic run_instr(input logic [19:0] ins, input logic [3:0] af);
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [14:0] ev, em;
        int  path[$];
        int  code;
        bit  def, arith, mov, cmp, cx;
        op    = ins[15:14];
        funct = ins[13:8];
        alu_info(funct, code, def, arith, mov, cmp);
        cx = cond_holds(ins[19:16], mflags);
        path = {0, 1};
        case (op)
            2'b01: begin
                path.push_back(2);
                if (funct[0]) begin path.push_back(3); path.push_back(4); end
                else path.push_back(5);
            end
            2'b10: path.push_back(9);
            2'b00: begin
                path.push_back(funct[5] ? 7 : 6);
                if (!cmp) path.push_back(8);
            end
            default: ;
        endcase
        for (int k = 0; k < path.size(); k++) begin
            @(negedge clk);
            if (k == 0) begin
                check_val("flags", 32'(dut.flags_r), 32'(mflags));
                bus.Instr    = ins;
                bus.ALUFlags = af;
            end
            check_val($sformatf("state_i%05h_k%0d", ins, k), 32'(bus.State), 32'(path[k]));
            exp_ctl(path[k], ins[3:0], cx, def, code, mov, ev, em);
            check_val($sformatf("ctl_i%05h_s%0d", ins, path[k]), 32'(obs_ctl() & em), 32'(ev & em));
            if (k == 1) begin
                check_val("immsrc", 32'(bus.ImmSrc), 32'(op));
                check_val("regsrc0", 32'(bus.RegSrc[0]), 32'(op == 2'b10));
                if (op == 2'b01 && !funct[0]) check_val("regsrc1_str", 32'(bus.RegSrc[1]), 32'd1);
                if (op == 2'b00 && !funct[5]) check_val("regsrc1_dp", 32'(bus.RegSrc[1]), 32'd0);
            end
        end
        if (op == 2'b00 && funct[0] && cx && def) begin
            mflags[3:2] = af[3:2];
            if (arith) mflags[1:0] = af[1:0];
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.Instr = 20'h00000;
        bus.ALUFlags = 4'h0;
        mflags = 4'h0;
        repeat (2) begin
            @(negedge clk);
            check_val("rst_state", 32'(bus.State), 32'd0);
            check_val("rst_en", 32'({bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite}), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(20'hE2821, 4'h0);   // ADD R1,R2,#5
        run_instr(20'hE3A03, 4'hF);   // MOV R3,#7, no S
        run_instr(20'hE5904, 4'h0);   // LDR
        run_instr(20'hE5804, 4'h0);   // STR
        run_instr(20'hE0512, 4'h4);   // SUBS -> Z=1
        run_instr(20'h0A000, 4'h0);   // BEQ taken
        run_instr(20'hE0512, 4'h0);   // SUBS -> Z=0
        run_instr(20'h0A000, 4'h0);   // BEQ not taken
        run_instr(20'hE3510, 4'h4);   // CMP or undefined
        run_instr(20'hEC000, 4'h0);   // op=11, back to FETCH
        run_instr(20'hE090F, 4'hA);   // ADDS to PC
        run_instr(20'hF2821, 4'h0);   // never-condition
        repeat (200) run_instr(rand_instr(), 4'($urandom_range(0, 15)));

        // Reset in the middle of an LDR.
        run_instr(20'hE0512, 4'hB);
        @(negedge clk);
        check_val("mid_s0", 32'(bus.State), 32'd0);
        bus.Instr = 20'hE5904;
        @(negedge clk);
        check_val("mid_s1", 32'(bus.State), 32'd1);
        @(negedge clk);
        check_val("mid_s2", 32'(bus.State), 32'd2);
        reset = 1'b1;
        #1 check_val("mid_rst_en", 32'({bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite}), 32'd0);
        @(negedge clk);
        check_val("mid_rst_state", 32'(bus.State), 32'd0);
        check_val("mid_rst_en2", 32'({bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite}), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        mflags = 4'h0;
        repeat (40) run_instr(rand_instr(), 4'($urandom_range(0, 15)));
        @(negedge clk);
        check_val("flags_end", 32'(dut.flags_r), 32'(mflags));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
